// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the data-bus SRAM responder: access size encoding,
// responder FSM states and a size-to-byte-count helper.
package dbus_sram_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_resp_state_t;

  // Unlisted encodings impose no alignment constraint.
  function automatic logic [3:0] size_bytes(input msize_t size);
    case (size)
      MSIZE1:  return 4'd1;
      MSIZE2:  return 4'd2;
      MSIZE4:  return 4'd4;
      MSIZE8:  return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundle between the core memory stage (master)
// and a memory-side responder (slave).
interface dbus_sram_responder_if;
  import dbus_sram_responder_pkg::*;

  logic        req_valid;
  logic [63:0] req_addr;
  msize_t      req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data, resp_err
  );

endinterface

// File: rtl/dbus_sram_bank.sv
// DEPTH_WORDS x 64 storage with a byte-strobed synchronous write port and an
// asynchronous read port; kept separate so it can be replaced by an SRAM macro.
module dbus_sram_bank #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [7:0]                     wstrb,
  input  logic [63:0]                    wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [63:0]                    rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (we && wstrb[b]) begin
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by an on-chip scratchpad, one outstanding request.
// Define DBUS_RESP_JITTER_EN to add 0-3 LFSR-driven extra wait cycles per access.
module dbus_sram_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dbus_sram_responder_if.slave  bus
);
  import dbus_sram_responder_pkg::*;

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam int          CNT_W = $clog2(LATENCY + 4);
  localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) * 64'd8;

  logic [63:0]      offset;
  logic [AW-1:0]    req_idx;
  logic [3:0]       nbytes;
  logic             in_range;
  logic             misaligned;
  logic             req_err;
  logic [63:0]      bank_rdata;
  logic             bank_we;
  logic [CNT_W-1:0] cnt_load;

  dbus_resp_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    idx_q;
  logic [7:0]       strobe_q;
  logic [63:0]      data_q;
  logic [63:0]      rd_word;
  logic             err_q;

  // An address below the base wraps to a huge offset, so one compare covers both bounds.
  assign offset     = bus.req_addr - BASE_ADDR;
  assign in_range   = offset < SPAN;
  assign req_idx    = offset[AW+2:3];
  assign nbytes     = size_bytes(bus.req_size);
  assign misaligned = (bus.req_addr[3:0] & (nbytes - 4'd1)) != 4'd0;
  assign req_err    = !in_range || misaligned;

`ifdef DBUS_RESP_JITTER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  // The write lands at the edge closing RESP; an async reset leaves RESP first, dropping it.
  assign bank_we = (state == RESP) && !err_q && (strobe_q != 8'd0);

  dbus_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (idx_q),
    .wstrb (strobe_q),
    .wdata (data_q),
    .raddr (req_idx),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      rd_word  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            idx_q    <= req_idx;
            strobe_q <= bus.req_strobe;
            data_q   <= bus.req_data;
            err_q    <= req_err;
            rd_word  <= req_err ? 64'd0 : bank_rdata;
            cnt      <= cnt_load;
            state    <= (cnt_load == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.resp_addr_ok = (state == IDLE) && bus.req_valid && !reset;
  assign bus.resp_data_ok = (state == RESP) && bus.req_valid;
  assign bus.resp_data    = bus.resp_data_ok ? rd_word : 64'd0;
  assign bus.resp_err     = bus.resp_data_ok && err_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Randomized self-checking bench for dbus_sram_responder against a byte-level
// memory model; honours DBUS_RESP_JITTER_EN for the latency check.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int          DEPTH  = 1024;
  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam int          LAT    = 2;
  localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'd8;
  localparam int          NWORDS = 16;

  logic clk;
  logic reset;

  dbus_sram_responder_if bus ();

  dbus_sram_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_compared;
  int          n_mismatched;
  logic [63:0] ref_mem [NWORDS];
  logic        known   [NWORDS];
  logic [63:0] last_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference behaviour: error on out-of-window or misaligned, else return the
  // old word and merge strobed bytes into it.
  task automatic modelApply(input logic [63:0] addr, input msize_t size,
                            input logic [7:0] strobe, input logic [63:0] data,
                            output logic [63:0] exp_data, output logic exp_err,
                            output logic exp_known);
    int nbytes;
    int idx;
    nbytes    = 1 << int'(size);
    exp_err   = (addr < BASE) || (addr >= BASE + SPAN) || ((addr % 64'(nbytes)) != 64'd0);
    exp_data  = 64'd0;
    exp_known = 1'b1;
    if (!exp_err) begin
      idx       = int'((addr - BASE) / 64'd8);
      exp_data  = ref_mem[idx];
      exp_known = known[idx];
      if (strobe != 8'd0) begin
        for (int b = 0; b < 8; b++) begin
          if (strobe[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        known[idx] = known[idx] || (strobe == 8'hFF);
      end
    end
  endtask

  task automatic applyStimulus(input logic [63:0] addr, input msize_t size,
                               input logic [7:0] strobe, input logic [63:0] data);
    logic [63:0] exp_data;
    logic        exp_err;
    logic        exp_known;
    int          cycles;
    bit          seen;
    modelApply(addr, size, strobe, data, exp_data, exp_err, exp_known);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_size   = size;
    bus.req_strobe = strobe;
    bus.req_data   = data;
    #1;
    checkOutput("addr_ok", 64'(bus.resp_addr_ok), 64'd1);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < LAT + 8) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.resp_data_ok) seen = 1'b1;
    end
    checkOutput("data_ok_seen", 64'(seen), 64'd1);
`ifdef DBUS_RESP_JITTER_EN
    checkOutput("latency_range", 64'(cycles >= LAT && cycles <= LAT + 3), 64'd1);
`else
    checkOutput("latency", 64'(cycles), 64'(LAT));
`endif
    checkOutput("resp_err", 64'(bus.resp_err), 64'(exp_err));
    if (exp_known) checkOutput("resp_data", bus.resp_data, exp_data);
    last_rdata = bus.resp_data;
  endtask

  task automatic idleBus();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Reset lands either in WAIT or in RESP of a write to word 4; the write must vanish.
  task automatic resetMidWrite(input bit at_resp);
    int cycles;
    bit seen;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = BASE + 64'h20;
    bus.req_size   = MSIZE8;
    bus.req_strobe = 8'hFF;
    bus.req_data   = {$urandom, $urandom};
    #1;
    checkOutput("rst_addr_ok", 64'(bus.resp_addr_ok), 64'd1);
    @(posedge clk);
    #1;
    if (at_resp) begin
      cycles = 1;
      seen   = bus.resp_data_ok;
      while (!seen && cycles < LAT + 8) begin
        @(posedge clk);
        #1;
        cycles++;
        seen = bus.resp_data_ok;
      end
      checkOutput("rst_resp_seen", 64'(seen), 64'd1);
    end
    reset = 1'b1;
    #1;
    checkOutput("rst_data_ok", 64'(bus.resp_data_ok), 64'd0);
    checkOutput("rst_addr_ok_low", 64'(bus.resp_addr_ok), 64'd0);
    checkOutput("rst_resp_data", bus.resp_data, 64'd0);
    checkOutput("rst_resp_err", 64'(bus.resp_err), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset         = 1'b0;
    applyStimulus(BASE + 64'h20, MSIZE8, 8'h00, 64'd0);
  endtask

  initial begin
    logic [63:0] addr;
    logic [63:0] exp_data;
    logic        exp_err;
    logic        exp_known;
    msize_t      size;
    int          nbytes;
    int          off;
    int          word;
    int          n_random;
    bit          seen;
    logic [7:0]  strobe;

    n_compared   = 0;
    n_mismatched = 0;
    last_rdata   = 64'd0;
    for (int i = 0; i < NWORDS; i++) begin
      ref_mem[i] = 64'd0;
      known[i]   = 1'b0;
    end

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 64'd0;
    bus.req_size   = MSIZE1;
    bus.req_strobe = 8'd0;
    bus.req_data   = 64'd0;
    #3;
    checkOutput("reset_data_ok", 64'(bus.resp_data_ok), 64'd0);
    checkOutput("reset_addr_ok", 64'(bus.resp_addr_ok), 64'd0);
    checkOutput("reset_resp_data", bus.resp_data, 64'd0);
    checkOutput("reset_resp_err", 64'(bus.resp_err), 64'd0);
    bus.req_valid = 1'b1;
    #1;
    checkOutput("reset_addr_ok_valid", 64'(bus.resp_addr_ok), 64'd0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] preloading %0d words", NWORDS);
    for (int i = 0; i < NWORDS; i++) begin
      applyStimulus(BASE + 64'(8 * i), MSIZE8, 8'hFF, {$urandom, $urandom});
    end

    applyStimulus(64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788);
    applyStimulus(64'h8000_0010, MSIZE8, 8'h00, 64'd0);
    checkOutput("wr_rd_const", last_rdata, 64'h1122_3344_5566_7788);

    applyStimulus(64'h8000_0018, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(64'h8000_0018, MSIZE4, 8'h0C, 64'h0000_0000_ABCD_0000);
    applyStimulus(64'h8000_0018, MSIZE8, 8'h00, 64'd0);
    checkOutput("merge_const", last_rdata, 64'hFFFF_FFFF_ABCD_FFFF);

    applyStimulus(64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0);
    checkOutput("oor_data_const", last_rdata, 64'd0);
    applyStimulus(BASE + SPAN, MSIZE8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
    applyStimulus(BASE, MSIZE8, 8'h00, 64'd0);

    applyStimulus(64'h8000_0002, MSIZE4, 8'h3C, 64'h0000_5A5A_5A5A_0000);
    applyStimulus(BASE, MSIZE8, 8'h00, 64'd0);

    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        word   = $urandom_range(0, NWORDS - 1);
        strobe = 8'($urandom_range(1, 255));
        applyStimulus(BASE + 64'(8 * word), MSIZE8, strobe, {$urandom, $urandom});
      end else begin
        applyStimulus(BASE + 64'(8 * word), MSIZE8, 8'h00, 64'd0);
      end
    end

    // Valid withdrawn after accept: the write still lands but data_ok stays low.
    idleBus();
    @(posedge clk);
    #1;
    addr = BASE + 64'h28;
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_size   = MSIZE8;
    bus.req_strobe = 8'hF0;
    bus.req_data   = {$urandom, $urandom};
    modelApply(addr, MSIZE8, 8'hF0, bus.req_data, exp_data, exp_err, exp_known);
    #1;
    checkOutput("drop_addr_ok", 64'(bus.resp_addr_ok), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < LAT + 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.resp_data_ok || bus.resp_err) seen = 1'b1;
    end
    checkOutput("drop_gated", 64'(seen), 64'd0);
    applyStimulus(addr, MSIZE8, 8'h00, 64'd0);

    resetMidWrite(1'b0);
    resetMidWrite(1'b1);

`ifdef DBUS_RESP_JITTER_EN
    n_random = 1000;
`else
    n_random = 200;
`endif
    for (int i = 0; i < n_random; i++) begin
      size   = msize_t'($urandom_range(0, 3));
      nbytes = 1 << int'(size);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) addr = BASE - 64'(8 * $urandom_range(1, 4));
        else                           addr = BASE + SPAN + 64'(8 * $urandom_range(0, 3));
      end else begin
        off = $urandom_range(0, 7);
        if ($urandom_range(0, 3) != 0) off = off & ~(nbytes - 1);
        addr = BASE + 64'(8 * $urandom_range(0, NWORDS - 1) + off);
      end
      strobe = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(1, 255));
      applyStimulus(addr, size, strobe, {$urandom, $urandom});
    end
    idleBus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
